// File: rtl/iq_modulator_if.sv
// iq_modulator_if -- handshake and data bundle for the IQ modulator.
//
// Signals:
//   phase_inc        carrier phase increment per clock (f = phase_inc * fclk / 2^32)
//   hold_count       clocks each I/Q pair is held; 0 behaves as 1
//   i_sample         signed baseband I sample
//   q_sample         signed baseband Q sample
//   in_valid         an I/Q pair is presented
//   in_ready         modulator accepts the pair this cycle
//   clear_underflow  clears the sticky underflow flag
//   out_sample       signed modulated passband sample
//   out_valid        out_sample carries modulated data
//   underflow        sticky: input starved at a hold boundary
//
// Modports: master drives the stimulus side, slave is the modulator.

interface iq_modulator_if;
    logic        [31:0] phase_inc;
    logic        [15:0] hold_count;
    logic signed [13:0] i_sample;
    logic signed [13:0] q_sample;
    logic               in_valid;
    logic               in_ready;
    logic               clear_underflow;
    logic signed [13:0] out_sample;
    logic               out_valid;
    logic               underflow;

    modport master (
        output phase_inc, hold_count, i_sample, q_sample, in_valid, clear_underflow,
        input  in_ready, out_sample, out_valid, underflow
    );

    modport slave (
        input  phase_inc, hold_count, i_sample, q_sample, in_valid, clear_underflow,
        output in_ready, out_sample, out_valid, underflow
    );
endinterface

// File: rtl/iq_modulator.sv
// iq_modulator -- quadrature modulator: out = (I*cos - Q*sin) >>> 13 with a 32-bit NCO.
//
// Ports:
//   clk_i    single clock, all logic on the rising edge
//   reset_i  synchronous, active-high reset
//   iq_io    iq_modulator_if.slave bundle (inputs, handshake, output sample, flags)
//
// Behaviour:
//   - Phase accumulator runs freely; LUT index is phase[31:22] (1024-point cos/sin).
//   - Each accepted I/Q pair is held for max(hold_count,1) clocks (zero-order hold).
//   - FSM Idle/Run/Starved; starving at a hold boundary sets the sticky underflow flag.
//   - Four registered stages: LUT address, LUT data, products, difference/shift/limit.
//     A pair accepted on edge n is registered on out on edge n+3, i.e. visible in
//     the cycle that edge n+4 samples.
//
// Configuration macro: IQ_MODULATOR_SAT_EN -- when defined, the shifted result is
// clamped to [-8192, 8191]; otherwise its low 14 bits are output (two's-complement wrap).

module iq_modulator (
    input  logic          clk_i,
    input  logic          reset_i,
    iq_modulator_if.slave iq_io
);

    // Q30 fixed-point pi, used only to build the sine table at elaboration.
    localparam longint PiQ30 = 64'sd3373259426;

    typedef enum logic [1:0] {StIdle, StRun, StStarved} state_e;

    // round(8191 * sin(pi*k/512)) for k in [0,256], Taylor series in Q30.
    function automatic int unsigned quarter_sin(input int unsigned k);
        longint x;
        longint x2;
        longint term;
        longint acc;
        x    = (longint'(k) * PiQ30) / 64'sd512;
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int n = 1; n < 12; n++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
            acc  = acc + term;
        end
        return 32'((acc * 64'sd8191 + (64'sd1 <<< 29)) >>> 30);
    endfunction

    // Fold a 10-bit index onto the quarter-wave table: second/fourth quadrants mirror.
    function automatic logic [8:0] fold_idx(input logic [9:0] k);
        return k[8] ? (9'd256 - {1'b0, k[7:0]}) : {1'b0, k[7:0]};
    endfunction

    // Quarter-wave sine ROM, constant after elaboration.
    logic [12:0] quarter_tab [0:256];
    for (genvar g = 0; g < 257; g++) begin : g_quarter_tab
        localparam int unsigned Mag = quarter_sin(g);
        assign quarter_tab[g] = 13'(Mag);
    end

    // ---------------- Control ----------------
    state_e             state_q;
    logic        [15:0] hold_cnt_q;
    logic signed [13:0] i_h_q;
    logic signed [13:0] q_h_q;
    logic               in_ready_q;
    logic               underflow_q;
    logic        [31:0] phase_q;

    logic        accept;
    logic        starve;
    logic [15:0] load_cnt;

    assign accept   = iq_io.in_valid && in_ready_q;
    assign load_cnt = (iq_io.hold_count == 16'd0) ? 16'd0 : iq_io.hold_count - 16'd1;
    // Hold expired and nothing new offered.
    assign starve   = (state_q == StRun) && (hold_cnt_q == 16'd0) && !accept;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_q + iq_io.phase_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            hold_cnt_q  <= '0;
            i_h_q       <= '0;
            q_h_q       <= '0;
            in_ready_q  <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            if (accept) begin
                state_q    <= StRun;
                hold_cnt_q <= load_cnt;
                i_h_q      <= iq_io.i_sample;
                q_h_q      <= iq_io.q_sample;
                in_ready_q <= (load_cnt == 16'd0);
            end else begin
                case (state_q)
                    StRun: begin
                        if (hold_cnt_q != 16'd0) begin
                            hold_cnt_q <= hold_cnt_q - 16'd1;
                            in_ready_q <= (hold_cnt_q == 16'd1);
                        end else begin
                            state_q    <= StStarved;
                            in_ready_q <= 1'b1;
                        end
                    end
                    default: ;  // Idle and Starved just wait for a pair
                endcase
            end
            // Setting wins over a simultaneous clear.
            if (starve) begin
                underflow_q <= 1'b1;
            end else if (iq_io.clear_underflow) begin
                underflow_q <= 1'b0;
            end
        end
    end

    // ---------------- Datapath pipeline ----------------
    logic        [9:0]  addr_q;
    logic signed [13:0] s1_i_q, s1_q_q;
    logic               s1_vld_q;

    logic signed [13:0] cos_d, sin_d, cos_q, sin_q;
    logic signed [13:0] s2_i_q, s2_q_q;
    logic               s2_vld_q;

    logic signed [27:0] prod_i_d, prod_q_d, prod_i_q, prod_q_q;
    logic               s3_vld_q;

    logic signed [28:0] diff;
    logic signed [15:0] y;
    logic signed [13:0] out_d, out_q;
    logic               out_vld_q;

    logic        [9:0]  cos_idx;
    logic signed [13:0] cos_mag, sin_mag;

    always_comb begin
        cos_idx = addr_q + 10'd256;
        sin_mag = signed'({1'b0, quarter_tab[fold_idx(addr_q)]});
        cos_mag = signed'({1'b0, quarter_tab[fold_idx(cos_idx)]});
        // Upper half of the circle is negative.
        sin_d   = addr_q[9] ? -sin_mag : sin_mag;
        cos_d   = cos_idx[9] ? -cos_mag : cos_mag;
    end

    always_comb begin
        prod_i_d = 28'(s2_i_q) * 28'(cos_q);
        prod_q_d = 28'(s2_q_q) * 28'(sin_q);
    end

    always_comb begin
        diff = $signed({prod_i_q[27], prod_i_q}) - $signed({prod_q_q[27], prod_q_q});
        // Dropping 13 LSBs of a signed value is a floor shift.
        y    = signed'(diff[28:13]);
`ifdef IQ_MODULATOR_SAT_EN
        if (y > 16'sd8191) begin
            out_d = 14'sh1FFF;
        end else if (y < -16'sd8192) begin
            out_d = 14'sh2000;
        end else begin
            out_d = y[13:0];
        end
`else
        out_d = y[13:0];
`endif
    end

    logic unused_lsbs;
    assign unused_lsbs = ^diff[12:0];
`ifndef IQ_MODULATOR_SAT_EN
    logic unused_msbs;
    assign unused_msbs = ^y[15:14];
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q    <= '0;
            s1_i_q    <= '0;
            s1_q_q    <= '0;
            s1_vld_q  <= 1'b0;
            cos_q     <= '0;
            sin_q     <= '0;
            s2_i_q    <= '0;
            s2_q_q    <= '0;
            s2_vld_q  <= 1'b0;
            prod_i_q  <= '0;
            prod_q_q  <= '0;
            s3_vld_q  <= 1'b0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            // Stage 1 sees the pair being loaded this edge and the pre-edge phase.
            addr_q    <= phase_q[31:22];
            s1_i_q    <= accept ? iq_io.i_sample : i_h_q;
            s1_q_q    <= accept ? iq_io.q_sample : q_h_q;
            s1_vld_q  <= s1_vld_q | accept;
            cos_q     <= cos_d;
            sin_q     <= sin_d;
            s2_i_q    <= s1_i_q;
            s2_q_q    <= s1_q_q;
            s2_vld_q  <= s1_vld_q;
            prod_i_q  <= prod_i_d;
            prod_q_q  <= prod_q_d;
            s3_vld_q  <= s2_vld_q;
            out_q     <= s3_vld_q ? out_d : 14'sd0;
            out_vld_q <= s3_vld_q;
        end
    end

    assign iq_io.in_ready   = in_ready_q;
    assign iq_io.underflow  = underflow_q;
    assign iq_io.out_sample = out_q;
    assign iq_io.out_valid  = out_vld_q;

endmodule

// File: tb/tb_iq_modulator.sv
// tb_iq_modulator -- directed, self-checking bench for iq_modulator.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point,
// so each step() views the registers written by the edge just passed.

module tb_iq_modulator;

    logic clk;
    logic reset;

    iq_modulator_if iq_if ();

    iq_modulator dut (
        .clk_i   (clk),
        .reset_i (reset),
        .iq_io   (iq_if)
    );

    initial clk = 1'b0;
    always #40 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input int i, input int q, input int hold);
        iq_if.in_valid   = vld;
        iq_if.i_sample   = 14'(i);
        iq_if.q_sample   = 14'(q);
        iq_if.hold_count = 16'(hold);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive(1'b0, 0, 0, 1);
        iq_if.clear_underflow = 1'b0;
        repeat (3) step();
        reset = 1'b0;
    endtask

    int vi [6] = '{100, 5, 8191, 0, -100, 1};
    int vq [6] = '{7, -4096, 3, -8192, 50, 1000};
    int vexp [6] = '{99, 4095, -8191, -8191, -100, -1000};
    int sat_exp;

    initial begin
        reset = 1'b1;
        iq_if.phase_inc = '0;
        iq_if.clear_underflow = 1'b0;
        drive(1'b0, 0, 0, 1);

        // Reset state, during reset and on the first cycle after it.
        apply_reset();
        reset = 1'b1;
        check("rst_out", int'(iq_if.out_sample), 0);
        check("rst_vld", int'(iq_if.out_valid), 0);
        check("rst_rdy", int'(iq_if.in_ready), 1);
        check("rst_uf", int'(iq_if.underflow), 0);
        reset = 1'b0;
        step();
        check("post_rst_out", int'(iq_if.out_sample), 0);
        check("post_rst_vld", int'(iq_if.out_valid), 0);
        check("post_rst_rdy", int'(iq_if.in_ready), 1);
        check("post_rst_uf", int'(iq_if.underflow), 0);

        // Quarter-rate carrier, I=4096: 4095, 0, -4096, 0.
        apply_reset();
        iq_if.phase_inc = 32'h4000_0000;
        drive(1'b1, 4096, 0, 8);
        step();
        drive(1'b0, 0, 0, 8);
        check("qr_rdy_hold", int'(iq_if.in_ready), 0);
        step();
        step();
        check("qr_vld_early", int'(iq_if.out_valid), 0);
        step();
        check("qr_vld", int'(iq_if.out_valid), 1);
        check("qr_out0", int'(iq_if.out_sample), 4095);
        step();
        check("qr_out1", int'(iq_if.out_sample), 0);
        step();
        check("qr_out2", int'(iq_if.out_sample), -4096);
        step();
        check("qr_out3", int'(iq_if.out_sample), 0);

        // Full-scale pair at k=128: 11583 saturates or wraps.
        apply_reset();
        iq_if.phase_inc = 32'h2000_0000;
        step();
        drive(1'b1, 8191, -8192, 4);
        step();
        drive(1'b0, 0, 0, 4);
        repeat (3) step();
`ifdef IQ_MODULATOR_SAT_EN
        sat_exp = 8191;
`else
        sat_exp = -4801;
`endif
        check("fs_out", int'(iq_if.out_sample), sat_exp);

        // Starvation after a 3-clock hold, then clear; DC carrier (cos=8191, sin=0).
        apply_reset();
        iq_if.phase_inc = '0;
        drive(1'b1, 1000, 500, 3);
        step();
        drive(1'b0, 0, 0, 3);
        check("st_rdy1", int'(iq_if.in_ready), 0);
        step();
        check("st_rdy2", int'(iq_if.in_ready), 0);
        step();
        check("st_rdy3", int'(iq_if.in_ready), 1);
        check("st_uf_pre", int'(iq_if.underflow), 0);
        step();
        check("st_uf", int'(iq_if.underflow), 1);
        check("st_rdy_starved", int'(iq_if.in_ready), 1);
        check("st_out", int'(iq_if.out_sample), 999);
        step();
        check("st_out_held", int'(iq_if.out_sample), 999);
        iq_if.clear_underflow = 1'b1;
        step();
        iq_if.clear_underflow = 1'b0;
        check("st_uf_clr", int'(iq_if.underflow), 0);
        // holdCount=0 acts as 1; set and clear together keep the flag.
        drive(1'b1, -2000, 0, 0);
        step();
        check("h0_rdy", int'(iq_if.in_ready), 1);
        check("h0_uf", int'(iq_if.underflow), 0);
        drive(1'b0, 0, 0, 0);
        iq_if.clear_underflow = 1'b1;
        step();
        iq_if.clear_underflow = 1'b0;
        check("setclr_uf", int'(iq_if.underflow), 1);
        step();
        step();
        check("h0_out", int'(iq_if.out_sample), -2000);

        // Back-to-back pairs, holdCount=1, quarter-rate carrier exercises I and Q.
        apply_reset();
        iq_if.phase_inc = 32'h4000_0000;
        for (int j = 0; j < 9; j++) begin
            if (j < 6) drive(1'b1, vi[j], vq[j], 1);
            else drive(1'b0, 0, 0, 1);
            step();
            if (j < 6) begin
                check($sformatf("b2b_rdy%0d", j), int'(iq_if.in_ready), 1);
                check($sformatf("b2b_uf%0d", j), int'(iq_if.underflow), 0);
            end
            if (j == 2) check("b2b_vld_early", int'(iq_if.out_valid), 0);
            if (j >= 3) begin
                check($sformatf("b2b_out%0d", j - 3), int'(iq_if.out_sample), vexp[j - 3]);
                check($sformatf("b2b_vld%0d", j - 3), int'(iq_if.out_valid), 1);
            end
        end

        // Reset mid-run discards the pipeline.
        apply_reset();
        iq_if.phase_inc = '0;
        drive(1'b1, 2000, 0, 2);
        repeat (10) step();
        check("mr_out_pre", int'(iq_if.out_sample), 1999);
        reset = 1'b1;
        drive(1'b0, 0, 0, 1);
        step();
        reset = 1'b0;
        check("mr_rdy", int'(iq_if.in_ready), 1);
        check("mr_out11", int'(iq_if.out_sample), 0);
        check("mr_vld11", int'(iq_if.out_valid), 0);
        drive(1'b1, -3000, 0, 1);
        step();
        drive(1'b0, 0, 0, 1);
        for (int c = 12; c <= 14; c++) begin
            check($sformatf("mr_out%0d", c), int'(iq_if.out_sample), 0);
            check($sformatf("mr_vld%0d", c), int'(iq_if.out_valid), 0);
            step();
        end
        check("mr_out_new", int'(iq_if.out_sample), -3000);
        check("mr_vld_new", int'(iq_if.out_valid), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
